// File: rtl/pipe_stage_hs_pkg.sv
// rtl/pipe_stage_hs_pkg.sv - shared constants and stage action type for pipe_stage_hs
package pipe_stage_hs_pkg;

   // Canonical bubble instruction (addi x0, x0, 0)
   localparam logic [31:0] INST_NOP    = 32'h0000_0013;
   localparam int          INST_W      = 32;
   localparam int          DATA_W      = 128;
   localparam int          STALL_CNT_W = 16;

   // What the output register does at the next edge (flush/reset override this)
   typedef enum logic [1:0] {
      ACT_HOLD      = 2'd0,
      ACT_LOAD_IN   = 2'd1,
      ACT_LOAD_SKID = 2'd2,
      ACT_BUBBLE    = 2'd3
   } stage_act_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - 1-entry holding register with valid flag
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         valid
);

   // Clear wins over load so a flush always empties the entry
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clr) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - valid/ready pipeline stage register with flush and stall counter (option: PIPE_SKID_EN)
module pipe_stage_hs
   import pipe_stage_hs_pkg::*;
#(
   parameter int            IW   = INST_W,
   parameter int            DW   = DATA_W,
   parameter logic [IW-1:0] NOP  = IW'(INST_NOP),
   parameter int            CNTW = STALL_CNT_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [IW-1:0]   in_inst_i,
   input  logic [DW-1:0]   in_data_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [IW-1:0]   out_inst_o,
   output logic [DW-1:0]   out_data_o,
   output logic [CNTW-1:0] stall_cnt_o
);

   logic       stalled;
   logic       out_free;
   stage_act_e act;

   assign stalled  = out_valid_o & ~out_ready_i;
   assign out_free = ~out_valid_o | out_ready_i;

`ifdef PIPE_SKID_EN
   logic              skid_valid;
   logic [IW+DW-1:0]  skid_q;
   logic              skid_load;
   logic              skid_clr;

   // Ready comes straight from a flop, so out_ready_i never reaches upstream
   assign in_ready_o = ~skid_valid;
   assign skid_load  = stalled & in_valid_i & ~skid_valid & ~flush_i;
   assign skid_clr   = flush_i | (out_free & skid_valid);

   pipe_skid_buf #(.W(IW + DW)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .clr   (skid_clr),
      .load  (skid_load),
      .d     ({in_inst_i, in_data_i}),
      .q     (skid_q),
      .valid (skid_valid)
   );

   // Skid content is older than anything upstream, so it refills the output first
   always_comb begin
      act = ACT_HOLD;
      if (out_free) begin
         if (skid_valid)      act = ACT_LOAD_SKID;
         else if (in_valid_i) act = ACT_LOAD_IN;
         else                 act = ACT_BUBBLE;
      end
   end
`else
   // Accept whenever the output slot is empty or being consumed this cycle
   assign in_ready_o = out_free;

   // Output slot either reloads from upstream, turns into a bubble, or holds
   always_comb begin
      act = ACT_HOLD;
      if (out_free) begin
         if (in_valid_i) act = ACT_LOAD_IN;
         else            act = ACT_BUBBLE;
      end
   end
`endif

   // Output register: reset, then flush, then the selected action; data holds on bubbles
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_o <= 1'b0;
         out_inst_o  <= NOP;
         out_data_o  <= '0;
      end else if (flush_i) begin
         out_valid_o <= 1'b0;
         out_inst_o  <= NOP;
      end else begin
         case (act)
            ACT_LOAD_IN: begin
               out_valid_o <= 1'b1;
               out_inst_o  <= in_inst_i;
               out_data_o  <= in_data_i;
            end
`ifdef PIPE_SKID_EN
            ACT_LOAD_SKID: begin
               out_valid_o <= 1'b1;
               {out_inst_o, out_data_o} <= skid_q;
            end
`endif
            ACT_BUBBLE: begin
               out_valid_o <= 1'b0;
               out_inst_o  <= NOP;
            end
            default: ;
         endcase
      end
   end

   // Saturating stall counter; keeps counting across flush, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_o <= '0;
      end else if (stalled && (stall_cnt_o != {CNTW{1'b1}})) begin
         stall_cnt_o <= stall_cnt_o + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - randomized and directed bench for pipe_stage_hs against a queue model
module tb_pipe_stage_hs;

   localparam int IW   = 32;
   localparam int DW   = 16;
   localparam int CNTW = 4;
   localparam int CNT_MAX = 15;
   localparam logic [31:0] NOP_EXP = 32'h0000_0013;
`ifdef PIPE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            flush_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [IW-1:0]   in_inst_i;
   logic [DW-1:0]   in_data_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [IW-1:0]   out_inst_o;
   logic [DW-1:0]   out_data_o;
   logic [CNTW-1:0] stall_cnt_o;

   typedef struct packed {
      logic [IW-1:0] inst;
      logic [DW-1:0] data;
   } beat_t;

   beat_t q_model[$];
   int    cnt_model = 0;
   int    n_tests = 0;
   int    n_fail = 0;
   bit    chk_en = 1'b0;
   int    seq = 100;

   pipe_stage_hs #(.IW(IW), .DW(DW), .CNTW(CNTW)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_inst_i   (in_inst_i),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_inst_o  (out_inst_o),
      .out_data_o  (out_data_o),
      .stall_cnt_o (stall_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Stage capacity: base mode refills only into a free/draining slot, skid mode holds two
   function automatic bit model_ready();
      if (CAP == 2) return q_model.size() < 2;
      return (q_model.size() == 0) || out_ready_i;
   endfunction

   task automatic compare_outputs();
      check("valid", out_valid_o, q_model.size() > 0);
      if (q_model.size() > 0) begin
         check("inst", out_inst_o, q_model[0].inst);
         check("data", out_data_o, q_model[0].data);
      end else begin
         check("inst_nop", out_inst_o, NOP_EXP);
      end
      check("ready", in_ready_o, model_ready());
      check("stall_cnt", stall_cnt_o, cnt_model);
   endtask

   // Drive one cycle, compare before the edge, then advance the model past the edge
   task automatic step(input logic v, input logic [IW-1:0] inst, input logic [DW-1:0] data,
                       input logic rdy, input logic fl, input logic r);
      bit    acc;
      beat_t b;
      rst = r; flush_i = fl; in_valid_i = v; in_inst_i = inst; in_data_i = data;
      out_ready_i = rdy;
      #1;
      if (chk_en) compare_outputs();
      acc = v && model_ready();
      b.inst = inst;
      b.data = data;
      @(posedge clk);
      if (r) begin
         q_model.delete();
         cnt_model = 0;
      end else begin
         if (q_model.size() > 0 && !rdy && cnt_model < CNT_MAX) cnt_model++;
         if (fl) begin
            q_model.delete();
         end else begin
            if (q_model.size() > 0 && rdy) void'(q_model.pop_front());
            if (acc) q_model.push_back(b);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_inst_i = '0; in_data_i = '0;
      out_ready_i = 1'b0;
      @(negedge clk);

      // T1 reset with a beat offered
      step(1'b1, 32'h55, 16'h55, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h55, 16'h55, 1'b1, 1'b0, 1'b1);
      chk_en = 1'b1;
      check("t1_valid", out_valid_o, 1'b0);
      check("t1_inst", out_inst_o, NOP_EXP);
      check("t1_data", out_data_o, 16'h0);
      check("t1_cnt", stall_cnt_o, 0);

      // T2 streaming 1..8
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 32'(k), 16'(k * 3), 1'b1, 1'b0, 1'b0);
         check("t2_inst", out_inst_o, k);
      end
      check("t2_cnt", stall_cnt_o, 0);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // T3 backpressure
      step(1'b1, 32'hA, 16'hA0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 32'hB, 16'hB0, 1'b0, 1'b0, 1'b0);
      check("t3_hold", out_inst_o, 32'hA);
      check("t3_cnt", stall_cnt_o, 3);
      check("t3_ready", in_ready_o, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_SKID_EN
      check("t3_b_after_a", out_inst_o, 32'hB);
`else
      check("t3_drained", out_valid_o, 1'b0);
`endif
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // T4 flush during stall
      step(1'b1, 32'hA1, 16'h1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'hB1, 16'h2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hC1, 16'h3, 1'b0, 1'b1, 1'b0);
      check("t4_valid", out_valid_o, 1'b0);
      check("t4_inst", out_inst_o, NOP_EXP);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      check("t4_still_empty", out_valid_o, 1'b0);

      // T5 counter saturation
      step(1'b1, 32'hD, 16'hD, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("t5_sat", stall_cnt_o, 15);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check("t5_clear", stall_cnt_o, 0);

      // T6 random traffic against the queue model
      for (int n = 0; n < 10000; n++) begin
         seq++;
         step($urandom_range(0, 3) != 0, 32'(seq), 16'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
              $urandom_range(0, 999) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
